// File: rtl/lwe_mod_reducer_pkg.sv
// Shared types and the centered-representative mapping for the LWE modular reducer.
// The mapping function is also used by the ciphertext packer.
package lwe_mod_pkg;

  localparam int MAX_N = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    ADJUST = 2'd2,
    OUTPUT = 2'd3
  } mod_state_t;

  // Maps a standard remainder r in [0, q) onto (-q/2, q/2], two's complement in n bits.
  // For even q the tie r == q/2 stays positive.
  function automatic logic [MAX_N-1:0] mod_center(input logic [MAX_N:0]   r,
                                                  input logic [MAX_N-1:0] q,
                                                  input int unsigned      n);
    logic [MAX_N:0]   q_ext;
    logic [MAX_N:0]   val;
    logic [MAX_N-1:0] mask;
    q_ext = {1'b0, q};
    mask  = '1;
    mask  = mask >> (MAX_N - n);
    if (r > (q_ext >> 1)) val = r - q_ext;
    else                  val = r;
    return val[MAX_N-1:0] & mask;
  endfunction

endpackage

// File: rtl/lwe_mod_reducer_if.sv
// Request/response handshake bundle for the LWE modular reducer.
interface lwe_mod_reducer_if #(
  parameter int N     = 32,
  parameter int W     = 2 * N,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [N-1:0]     in_q;
  logic             in_centered;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_rem;
  logic [TAG_W-1:0] out_tag;
  logic             out_div0;

  modport slave (
    input  in_valid, in_a, in_q, in_centered, in_tag, out_ready,
    output in_ready, out_valid, out_rem, out_tag, out_div0
  );

  modport master (
    output in_valid, in_a, in_q, in_centered, in_tag, out_ready,
    input  in_ready, out_valid, out_rem, out_tag, out_div0
  );
endinterface

// File: rtl/lwe_mod_step.sv
// One restoring-division iteration: shifts the next dividend bit into R and
// conditionally subtracts q. Purely combinational so several can be chained per cycle.
module lwe_mod_step #(
  parameter int N = 32
) (
  input  logic [N:0]   r,
  input  logic         bit_in,
  input  logic [N-1:0] q,
  output logic [N:0]   r_next
);
  logic [N+1:0] r_sh;
  logic [N+1:0] q_ext;

  assign r_sh   = {r, bit_in};
  assign q_ext  = (N+2)'(q);
  assign r_next = (r_sh >= q_ext) ? (N+1)'(r_sh - q_ext) : (N+1)'(r_sh);
endmodule

// File: rtl/lwe_mod_reducer.sv
// Handshaked modular reducer: W-cycle restoring division of a by q, then an
// optional centered mapping. One operation in flight, fixed data-independent latency.
//
//   state  | meaning
//   IDLE   | ready for a request; operands latched on accept
//   CALC   | one restoring step per cycle, MSB of a first, W cycles
//   ADJUST | select standard/centered remainder or flag divide-by-zero
//   OUTPUT | result valid, held until consumer accepts
module lwe_mod_reducer
  import lwe_mod_pkg::*;
#(
  parameter int N     = 32,
  parameter int W     = 2 * N,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  lwe_mod_reducer_if.slave bus
);
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  mod_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_reg;
  logic [N-1:0]     q_reg;
  logic             cent_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [N:0]       r_reg;
  logic [N:0]       r_step;
  logic [N-1:0]     rem_c;
  logic [N-1:0]     rem_reg;
  logic [TAG_W-1:0] otag_reg;
  logic             div0_reg;
  logic             accept;

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUTPUT);
  assign bus.out_rem   = rem_reg;
  assign bus.out_tag   = otag_reg;
  assign bus.out_div0  = div0_reg;

  lwe_mod_step #(.N(N)) u_step (
    .r      (r_reg),
    .bit_in (a_reg[cnt]),
    .q      (q_reg),
    .r_next (r_step)
  );

  assign rem_c = N'(mod_center((MAX_N+1)'(r_reg), MAX_N'(q_reg), N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = (bus.in_q == '0) ? ADJUST : CALC;
      CALC:    if (cnt == '0) state_next = ADJUST;
      ADJUST:  state_next = OUTPUT;
      OUTPUT:  if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_reg    <= '0;
      q_reg    <= '0;
      cent_reg <= 1'b0;
      tag_reg  <= '0;
      r_reg    <= '0;
      rem_reg  <= '0;
      otag_reg <= '0;
      div0_reg <= 1'b0;
    end else begin
      if (accept) begin
        a_reg    <= bus.in_a;
        q_reg    <= bus.in_q;
        cent_reg <= bus.in_centered;
        tag_reg  <= bus.in_tag;
        r_reg    <= '0;
        cnt      <= CNT_W'(W - 1);
      end
      if (state == CALC) begin
        r_reg <= r_step;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      // Result registers only load here, so they hold through OUTPUT and after the handshake.
      if (state == ADJUST) begin
        otag_reg <= tag_reg;
        if (q_reg == '0) begin
          rem_reg  <= '0;
          div0_reg <= 1'b1;
        end else begin
          rem_reg  <= cent_reg ? rem_c : r_reg[N-1:0];
          div0_reg <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_lwe_mod_reducer.sv
// Self-checking bench for lwe_mod_reducer at N=8, W=16: directed vectors,
// handshake corner cases and a randomized run against an arithmetic model.
module tb_lwe_mod_reducer;
  localparam int N     = 8;
  localparam int W     = 16;
  localparam int TAG_W = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  lwe_mod_reducer_if #(.N(N), .W(W), .TAG_W(TAG_W)) bus ();

  lwe_mod_reducer #(.N(N), .W(W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     a;
    logic [N-1:0]     q;
    logic             c;
    logic [TAG_W-1:0] tag;
    logic [N-1:0]     rem;
    logic             div0;
    int               lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain modulo, then fold the upper half down for centered mode.
  function automatic logic [N-1:0] ref_rem(input longint a, input longint q, input bit c);
    longint r;
    if (q == 0) return '0;
    r = a % q;
    if (c && (r > q / 2)) r = r - q;
    return N'(r);
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [N-1:0] q,
                          input logic c, input logic [TAG_W-1:0] tag);
    int g;
    g = 0;
    while (!bus.in_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_a        = a;
    bus.in_q        = q;
    bus.in_centered = c;
    bus.in_tag      = tag;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_a        = W'($urandom);
    bus.in_q        = N'($urandom);
    bus.in_centered = ~c;
    bus.in_tag      = TAG_W'($urandom);
  endtask

  // Returns the cycle index (accept cycle = 0) in which out_valid is first high.
  task automatic wait_out(output int lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.out_valid) begin
      chk("out_valid_timeout", 0, 1);
      lat = -1;
    end else begin
      lat = n + 1;
    end
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [N-1:0] q,
                           input logic c, input logic [TAG_W-1:0] tag,
                           input logic [N-1:0] rem, input logic div0, input int lat_exp);
    int lat;
    start_op(a, q, c, tag);
    wait_out(lat);
    chk({name, "_rem"}, bus.out_rem, rem);
    chk({name, "_tag"}, bus.out_tag, tag);
    chk({name, "_div0"}, bus.out_div0, div0);
    if (lat_exp > 0) chk({name, "_lat"}, lat, lat_exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int   lat;
    bit   ok;
    logic [N-1:0]     rem0;
    logic [TAG_W-1:0] tag0;
    logic             d0;

    errors = 0;
    checks = 0;
    vecs[0] = '{16'd1000,  8'd7,    1'b0, 4'd3,  8'd6,    1'b0, W + 2};
    vecs[1] = '{16'd1000,  8'd7,    1'b1, 4'd4,  8'hFF,   1'b0, W + 2};
    vecs[2] = '{16'd12,    8'd8,    1'b1, 4'd5,  8'd4,    1'b0, W + 2};
    vecs[3] = '{16'hFFFF,  8'hFF,   1'b0, 4'd6,  8'd0,    1'b0, W + 2};
    vecs[4] = '{16'd12345, 8'd1,    1'b0, 4'd7,  8'd0,    1'b0, W + 2};
    vecs[5] = '{16'd5,     8'hFF,   1'b0, 4'd8,  8'd5,    1'b0, W + 2};
    vecs[6] = '{16'hFFFF,  8'hFE,   1'b0, 4'd9,  8'h03,   1'b0, W + 2};
    vecs[7] = '{16'h1234,  8'd0,    1'b0, 4'hA,  8'd0,    1'b1, 2};
    vecs[8] = '{16'd1000,  8'd7,    1'b0, 4'hB,  8'd6,    1'b0, W + 2};
    vecs[9] = '{16'd12345, 8'd1,    1'b1, 4'hC,  8'd0,    1'b0, W + 2};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_a        = '0;
    bus.in_q        = '0;
    bus.in_centered = 1'b0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_out_rem",   bus.out_rem,   0);
    chk("rst_out_tag",   bus.out_tag,   0);
    chk("rst_out_div0",  bus.out_div0,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].q, vecs[i].c, vecs[i].tag,
                vecs[i].rem, vecs[i].div0, vecs[i].lat);

    // Back-pressure: result must stay frozen while out_ready is low.
    bus.out_ready = 1'b0;
    start_op(16'd1000, 8'd7, 1'b1, 4'd9);
    wait_out(lat);
    chk("bp_lat", lat, W + 2);
    rem0 = bus.out_rem;
    tag0 = bus.out_tag;
    d0   = bus.out_div0;
    chk("bp_rem", rem0, 8'hFF);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_rem != rem0 || bus.out_tag != tag0 || bus.out_div0 != d0 ||
          bus.in_ready || !bus.out_valid) ok = 1'b0;
    end
    chk("bp_hold_stable", ok, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    chk("bp_rem_kept", bus.out_rem, 8'hFF);
    chk("bp_tag_kept", bus.out_tag, 9);

    // Reset asserted in the 5th CALC cycle drops the operation.
    start_op(16'd1000, 8'd7, 1'b0, 4'd2);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid) ok = 1'b0;
    end
    chk("midrst_no_stale", ok, 1);
    run_check("post_rst", 16'd1000, 8'd7, 1'b0, 4'd1, 8'd6, 1'b0, W + 2);

    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0]     a;
      logic [N-1:0]     q;
      logic             c;
      logic [TAG_W-1:0] tag;
      int               sel;
      a   = W'($urandom);
      sel = int'($urandom_range(0, 15));
      if (sel == 0)      q = '0;
      else if (sel == 1) q = N'($urandom_range(1, 3));
      else               q = N'($urandom);
      c   = 1'($urandom);
      tag = TAG_W'($urandom);
      run_check("rand", a, q, c, tag, ref_rem(longint'(a), longint'(q), c),
                (q == 0), (q == 0) ? 2 : W + 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
